// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must index 0..WIDTH-1; a 1-bit counter is the floor so WIDTH=1 still works.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder cell, the single arithmetic element of the
// bit-serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in LSB first, one
// bit per clock, through one full-adder cell and a carry flop, with
// valid/ready handshakes on both sides.
// Optional build macro SERIAL_ADDER_SUB_EN adds a subtract control (sub) and a
// signed-overflow flag (ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             b_bit;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             accept;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  logic ovf_r;
  // Subtraction feeds the one's complement of b; the caller supplies the +1 via cin.
  assign b_bit = b_sh[0] ^ sub_r;
  assign ovf   = ovf_r;
`else
  assign b_bit = b_sh[0];
`endif

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (cnt == CNT_LAST);

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_bit),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so bit 0 lands in sum[0] after WIDTH shifts.
  always_comb begin
    sum_nxt            = sum_r >> 1;
    sum_nxt[WIDTH-1]   = fa_s;
  end

  // Control FSM, bit counter, carry flop and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sum_r <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r <= 1'b0;
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            carry <= cin;
            sum_r <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r <= sub;
            ovf_r <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_nxt;
          carry <= fa_co;
          cnt   <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          if (last_bit) begin
`ifdef SERIAL_ADDER_SUB_EN
            // Carry into the MSB is the current carry flop; carry out is the cell output.
            ovf_r <= carry ^ fa_co;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shift registers: loaded on acceptance, shifted right while running.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_r;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table-driven WIDTH=8 vectors plus
// hand-written sequences for hold, back-to-back, mid-operation reset and a
// WIDTH=1 truth-table sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, ovf8, sub1, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub8), .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADDER_SUB_EN
    , .sub(sub1), .ovf(ovf1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one WIDTH=8 operation from a negedge; returns at the negedge where out_valid is seen.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                     input logic isub, output logic [7:0] osum, output logic ocout,
                     output logic oovf, output int lat);
    int n;
    n = 0;
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    a8 = ia; b8 = ib; cin8 = icin; in_valid8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = isub;
`endif
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    a8 = ~ia; b8 = ~ib; cin8 = ~icin;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = ~isub;
`endif
    lat = 1;
    @(negedge clk);
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    osum  = sum8;
    ocout = cout8;
    oovf  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    oovf  = ovf8;
`endif
  endtask

  // Issue one WIDTH=1 operation; same timing conventions as op8.
  task automatic op1(input logic ia, input logic ib, input logic icin,
                     output logic osum, output logic ocout, output int lat);
    int n;
    n = 0;
    while (!in_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    a1 = ia; b1 = ib; cin1 = icin; in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    osum  = sum1[0];
    ocout = cout1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [7:0] rs;
    logic       rc, ro, s1, c1;
    logic [1:0] e1;
    logic [2:0] v3;
    int         lat, n;

    vt.push_back('{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1});
    vt.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
    vt.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
    vt.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vt.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vt.push_back('{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0});
    vt.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vt.push_back('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
    vt.push_back('{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0});
    sub8 = 1'b0;
    sub1 = 1'b0;
`endif

    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready8, 1);
    chk("rst out_valid", out_valid8, 0);
    chk("rst busy", busy8, 0);
    chk("rst sum", sum8, 0);
    chk("rst cout", cout8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven WIDTH=8 vectors.
    for (int i = 0; i < vt.size(); i++) begin
      op8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d sum", i), rs, vt[i].s);
      chk($sformatf("vec%0d cout", i), rc, vt[i].co);
      chk($sformatf("vec%0d latency", i), lat, 9);
`ifdef SERIAL_ADDER_SUB_EN
      chk($sformatf("vec%0d ovf", i), ro, vt[i].ov);
`endif
    end

    // Consumer stalls: result must hold while out_ready is low.
    @(negedge clk);
    out_ready8 = 1'b0;
    op8(8'hFF, 8'h01, 1'b1, 1'b0, rs, rc, ro, lat);
    chk("hold sum", rs, 8'h01);
    chk("hold cout", rc, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", k), out_valid8, 1);
      chk($sformatf("hold%0d sum", k), sum8, 8'h01);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    chk("hold release out_valid", out_valid8, 0);
    chk("hold release in_ready", in_ready8, 1);

    // Back-to-back with in_valid held high; operand changes while busy are ignored.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    a8 = 8'h03; b8 = 8'h04;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) chk("b2b busy", busy8, 1);
      if (out_valid8) chk("b2b first sum", sum8, 8'h03);
      if (in_ready8) break;
      n++;
    end
    chk("b2b in_ready low cycles", n, 9);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b second sum", sum8, 8'h07);
    chk("b2b second latency", lat, 9);
    @(negedge clk);

    // Reset in the middle of RUN (counter=3).
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", in_ready8, 1);
    chk("midrst out_valid", out_valid8, 0);
    chk("midrst busy", busy8, 0);
    chk("midrst sum", sum8, 0);
    chk("midrst cout", cout8, 0);
    op8(8'h10, 8'h20, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("postrst sum", rs, 8'h30);
    chk("postrst cout", rc, 0);

    // WIDTH=1: full-adder truth table, out_valid two cycles after accept.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      e1 = {1'b0, v3[2]} + {1'b0, v3[1]} + {1'b0, v3[0]};
      op1(v3[2], v3[1], v3[0], s1, c1, lat);
      chk($sformatf("w1 %0d sum", i), s1, e1[0]);
      chk($sformatf("w1 %0d cout", i), c1, e1[1]);
      chk($sformatf("w1 %0d latency", i), lat, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
